// File: rtl/stopwatch_timer_core.sv
// MM:SS up/down stopwatch/timer: tick prescaler, BCD counter with preset load,
// lap capture and a multiplexed 4-digit 7-segment driver that blinks on expiry or halt.
module stopwatch_timer_core #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 250_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        mode,
  input  logic        halt,
  input  logic        lap,
  input  logic        show_lap,
  output logic [15:0] bcd,
  output logic [15:0] lap_bcd,
  output logic        running,
  output logic        expired,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [15:0]   bcd_reg, bcd_next;
  logic [15:0]   lap_reg, lap_next;
  logic          running_reg, running_next;
  logic          expired_reg, expired_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [SW-1:0] scan_reg, scan_next;
  logic [1:0]    slot_reg, slot_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          phase_reg, phase_next;
  logic [7:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;

  logic [15:0] load_clamped, inc_val, dec_val, src;
  logic [4:0]  borrow;
  logic [3:0]  carry;
  logic [3:0]  digit;
  logic        tick, at_zero, scan_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Per-digit preset clamp plus ripple carry/borrow chains; tens digits roll at 5, units at 9.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] DMAX = (gi % 2 == 1) ? 4'd5 : 4'd9;
      logic [3:0] d;
      assign d = bcd_reg[gi*4 +: 4];
      assign load_clamped[gi*4 +: 4] = (load_val[gi*4 +: 4] > DMAX) ? DMAX : load_val[gi*4 +: 4];
      assign inc_val[gi*4 +: 4] = !carry[gi] ? d : ((d == DMAX) ? 4'd0 : d + 4'd1);
      assign dec_val[gi*4 +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? DMAX : d - 4'd1);
      assign borrow[gi+1] = borrow[gi] && (d == 4'd0);
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] && (d == DMAX);
      end
    end
  endgenerate

  assign at_zero = borrow[4];
  assign tick    = running_reg && (presc_reg == TICK_MAX);

  always_comb begin
    bcd_next     = bcd_reg;
    lap_next     = lap ? bcd_reg : lap_reg;
    running_next = running_reg;
    expired_next = expired_reg;
    presc_next   = presc_reg;
    if (running_reg) presc_next = tick ? '0 : presc_reg + PW'(1);
    if (tick) begin
      if (!mode) begin
        bcd_next = inc_val;
      end else begin
        bcd_next = at_zero ? 16'h0000 : dec_val;
        if (at_zero || dec_val == 16'h0000) begin
          running_next = 1'b0;
          expired_next = 1'b1;
        end
      end
    end
    if (clear) begin
      bcd_next     = 16'h0000;
      lap_next     = 16'h0000;
      running_next = 1'b0;
      expired_next = 1'b0;
      presc_next   = '0;
    end else if (load) begin
      bcd_next     = load_clamped;
      running_next = 1'b0;
      expired_next = 1'b0;
      presc_next   = '0;
    end else if (halt) begin
      running_next = 1'b0;
    end else if (start_stop) begin
      // A count-down parked at 00:00 refuses to start; stopping is always allowed.
      if (running_reg) running_next = 1'b0;
      else if (!(mode && at_zero)) running_next = 1'b1;
    end
  end

  always_comb begin
    scan_wrap = (scan_reg == SCAN_MAX);
    scan_next = scan_wrap ? '0 : scan_reg + SW'(1);
    slot_next = scan_wrap ? slot_reg + 2'd1 : slot_reg;
    blink_cnt_next = '0;
    phase_next     = 1'b0;
    if (expired_reg || halt) begin
      blink_cnt_next = (blink_cnt_reg == BLINK_MAX) ? '0 : blink_cnt_reg + BW'(1);
      phase_next     = (blink_cnt_reg == BLINK_MAX) ? ~phase_reg : phase_reg;
    end
    src = show_lap ? lap_reg : bcd_reg;
    case (slot_reg)
      2'd0: digit = src[3:0];
      2'd1: digit = src[7:4];
      2'd2: digit = src[11:8];
      default: digit = src[15:12];
    endcase
    seg_next = {slot_reg != 2'd2, seg7(digit)};
    an_next  = phase_reg ? 4'b1111 : ~(4'b0001 << slot_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg       <= 16'h0000;
      lap_reg       <= 16'h0000;
      running_reg   <= 1'b0;
      expired_reg   <= 1'b0;
      presc_reg     <= '0;
      scan_reg      <= '0;
      slot_reg      <= 2'd0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      seg_reg       <= 8'hC0;
      an_reg        <= 4'b1110;
    end else begin
      bcd_reg       <= bcd_next;
      lap_reg       <= lap_next;
      running_reg   <= running_next;
      expired_reg   <= expired_next;
      presc_reg     <= presc_next;
      scan_reg      <= scan_next;
      slot_reg      <= slot_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      seg_reg       <= seg_next;
      an_reg        <= an_next;
    end
  end

  assign bcd     = bcd_reg;
  assign lap_bcd = lap_reg;
  assign running = running_reg;
  assign expired = expired_reg;
  assign seg     = seg_reg;
  assign an      = an_reg;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed scenarios plus randomized traffic checked
// against a seconds-based reference model.
module tb_stopwatch_timer_core;
  localparam int TICK_DIV = 4, SCAN_DIV = 2, BLINK_DIV = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_stop = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0;
  logic halt = 1'b0, lap = 1'b0, show_lap = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] bcd, lap_bcd;
  logic running, expired;
  logic [7:0] seg;
  logic [3:0] an;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: values held as whole seconds.
  int m_val, m_lap, m_presc, m_scan, m_slot, m_bcnt;
  bit m_run, m_exp, m_phase;
  logic [7:0] m_seg;
  logic [3:0] m_an;

  stopwatch_timer_core #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .halt(halt), .lap(lap), .show_lap(show_lap),
    .bcd(bcd), .lap_bcd(lap_bcd), .running(running), .expired(expired), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sec_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int clamp_to_sec(input logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if ((i % 2) == 1 && d[i] > 5) d[i] = 5;
      if ((i % 2) == 0 && d[i] > 9) d[i] = 9;
    end
    return d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
  endfunction

  function automatic int digit_of(input int s, input int slot);
    case (slot)
      0: return (s % 60) % 10;
      1: return (s % 60) / 10;
      2: return (s / 60) % 10;
      default: return (s / 60) / 10;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_val = 0; m_lap = 0; m_presc = 0; m_scan = 0; m_slot = 0; m_bcnt = 0;
    m_run = 0; m_exp = 0; m_phase = 0; m_seg = 8'hC0; m_an = 4'b1110;
  endtask

  task automatic model_edge();
    bit tick, nr, ne, nph;
    int nv, nl, np, ns, nsl, nb, src;
    logic [7:0] nseg;
    logic [3:0] nan;
    tick = m_run && (m_presc == TICK_DIV - 1);
    nv = m_val; nl = lap ? m_val : m_lap; np = m_presc; nr = m_run; ne = m_exp;
    if (m_run) np = (m_presc + 1) % TICK_DIV;
    if (tick) begin
      if (!mode) nv = (m_val + 1) % 3600;
      else begin
        nv = (m_val > 0) ? m_val - 1 : 0;
        if (nv == 0) begin nr = 0; ne = 1; end
      end
    end
    if (clear) begin nv = 0; nl = 0; nr = 0; ne = 0; np = 0; end
    else if (load) begin nv = clamp_to_sec(load_val); nr = 0; ne = 0; np = 0; end
    else if (halt) nr = 0;
    else if (start_stop) begin
      if (m_run) nr = 0;
      else if (!(mode && m_val == 0)) nr = 1;
    end
    ns = m_scan + 1; nsl = m_slot;
    if (ns == SCAN_DIV) begin ns = 0; nsl = (m_slot + 1) % 4; end
    nb = 0; nph = 0;
    if (m_exp || halt) begin
      nb = m_bcnt + 1; nph = m_phase;
      if (nb == BLINK_DIV) begin nb = 0; nph = !m_phase; end
    end
    src = show_lap ? m_lap : m_val;
    nseg = {(m_slot != 2), seg7(digit_of(src, m_slot))};
    nan = m_phase ? 4'hF : 4'(15 & ~(1 << m_slot));
    m_val = nv; m_lap = nl; m_presc = np; m_run = nr; m_exp = ne;
    m_scan = ns; m_slot = nsl; m_bcnt = nb; m_phase = nph; m_seg = nseg; m_an = nan;
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then settle past the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
    n_checks++; if (lap_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_lap: got %h expected 0000", lap_bcd); end
    n_checks++; if (running !== 1'b0 || expired !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got run=%b exp=%b expected 0 0", running, expired); end
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b expected 1110", an); end
    n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL reset_seg: got %h expected c0", seg); end
    $display("test_reset done");
  endtask

  task automatic test_up_count();
    mode = 0; clear = 1; step(); clear = 0;
    start_stop = 1; step(); start_stop = 0;
    repeat (2400) step();
    n_checks++; if (bcd !== 16'h1000) begin n_fail++; $display("FAIL up_600_ticks: got %h expected 1000", bcd); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL up_running: got %b expected 1", running); end
    load_val = 16'h5959; load = 1; step(); load = 0;
    start_stop = 1; step(); start_stop = 0;
    repeat (3) step();
    n_checks++; if (bcd !== 16'h5959) begin n_fail++; $display("FAIL up_first_tick_latency: got %h expected 5959", bcd); end
    step();
    n_checks++; if (bcd !== 16'h0000 || running !== 1'b1) begin n_fail++; $display("FAIL up_wrap: got %h run=%b expected 0000 run=1", bcd, running); end
    $display("test_up_count done");
  endtask

  task automatic test_down_expiry();
    mode = 1; load_val = 16'h0003; load = 1; step(); load = 0;
    start_stop = 1; step(); start_stop = 0;
    repeat (11) step();
    n_checks++; if (bcd !== 16'h0001 || running !== 1'b1) begin n_fail++; $display("FAIL down_before_expiry: got %h run=%b expected 0001 run=1", bcd, running); end
    step();
    n_checks++; if (bcd !== 16'h0000 || running !== 1'b0 || expired !== 1'b1) begin n_fail++; $display("FAIL down_expiry: got %h run=%b exp=%b expected 0000 0 1", bcd, running, expired); end
    start_stop = 1; step(); start_stop = 0;
    repeat (5) step();
    n_checks++; if (running !== 1'b0 || expired !== 1'b1 || bcd !== 16'h0000) begin n_fail++; $display("FAIL down_restart_ignored: got %h run=%b exp=%b expected 0000 0 1", bcd, running, expired); end
    $display("test_down_expiry done");
  endtask

  task automatic test_pause();
    mode = 0; clear = 1; step(); clear = 0;
    start_stop = 1; step(); start_stop = 0;
    repeat (5) step();
    start_stop = 1; step(); start_stop = 0;
    n_checks++; if (running !== 1'b0 || bcd !== 16'h0001) begin n_fail++; $display("FAIL pause_stop: got %h run=%b expected 0001 run=0", bcd, running); end
    repeat (100) step();
    n_checks++; if (bcd !== 16'h0001) begin n_fail++; $display("FAIL pause_hold: got %h expected 0001", bcd); end
    start_stop = 1; step(); start_stop = 0;
    step();
    n_checks++; if (bcd !== 16'h0001) begin n_fail++; $display("FAIL pause_resume_early: got %h expected 0001", bcd); end
    step();
    n_checks++; if (bcd !== 16'h0002) begin n_fail++; $display("FAIL pause_resume_tick: got %h expected 0002", bcd); end
    $display("test_pause done");
  endtask

  task automatic test_priority();
    logic [15:0] v;
    lap = 1; step(); lap = 0;
    n_checks++; if (lap_bcd !== 16'h0002) begin n_fail++; $display("FAIL prio_lap_capture: got %h expected 0002", lap_bcd); end
    load_val = 16'h1234; clear = 1; load = 1; start_stop = 1; lap = 1; step();
    clear = 0; load = 0; start_stop = 0; lap = 0;
    n_checks++; if (bcd !== 16'h0000 || running !== 1'b0 || lap_bcd !== 16'h0000) begin n_fail++; $display("FAIL prio_clear: got %h run=%b lap=%h expected 0000 0 0000", bcd, running, lap_bcd); end
    load_val = 16'h7A9C; load = 1; step(); load = 0;
    n_checks++; if (bcd !== 16'h5959 || running !== 1'b0) begin n_fail++; $display("FAIL prio_load_clamp: got %h run=%b expected 5959 0", bcd, running); end
    halt = 1; start_stop = 1; step(); start_stop = 0; halt = 0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL prio_halt_blocks_start: got %b expected 0", running); end
    v = 16'($urandom);
    load_val = v; load = 1; step(); load = 0;
    n_checks++; if (bcd !== sec_to_bcd(clamp_to_sec(v))) begin n_fail++; $display("FAIL prio_random_load %h: got %h expected %h", v, bcd, sec_to_bcd(clamp_to_sec(v))); end
    $display("test_priority done");
  endtask

  task automatic test_lap_display();
    logic [3:0] an_exp [4];
    logic [7:0] seg_exp [4];
    logic [3:0] prev;
    bit found;
    int on_cnt;
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{8'hA4, 8'h99, 8'h40, 8'hC0};
    mode = 0; load_val = 16'h0042; load = 1; step(); load = 0;
    lap = 1; step(); lap = 0;
    n_checks++; if (lap_bcd !== 16'h0042) begin n_fail++; $display("FAIL lap_value: got %h expected 0042", lap_bcd); end
    load_val = 16'h1357; load = 1; show_lap = 1; step(); load = 0;
    found = 0; prev = an;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (prev == 4'b0111 && an == 4'b1110) found = 1;
      else prev = an;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL display_align: an never cycled 0111->1110, last %b", an); end
    if (found) begin
      for (int k = 0; k < 8; k++) begin
        n_checks++; if (an !== an_exp[k/2] || seg !== seg_exp[k/2]) begin n_fail++; $display("FAIL display_cycle%0d: got an=%b seg=%h expected an=%b seg=%h", k, an, seg, an_exp[k/2], seg_exp[k/2]); end
        if (k < 7) step();
      end
    end
    start_stop = 1; step(); start_stop = 0;
    halt = 1; step();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL halt_stops: got %b expected 0", running); end
    repeat (16) step();
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin step(); if (an == 4'b1111) on_cnt++; end
    n_checks++; if (on_cnt != 16) begin n_fail++; $display("FAIL halt_blink_duty: got %0d blank cycles of 32 expected 16", on_cnt); end
    halt = 0; show_lap = 0; step(); step();
    n_checks++; if (an === 4'b1111) begin n_fail++; $display("FAIL blink_release: got an=%b expected a lit digit", an); end
    $display("test_lap_display done");
  endtask

  task automatic test_random();
    int fails_before;
    fails_before = n_fail;
    for (int i = 0; i < 3000; i++) begin
      start_stop = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 79) == 0);
      load       = ($urandom_range(0, 39) == 0);
      lap        = ($urandom_range(0, 15) == 0);
      load_val   = 16'($urandom);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) show_lap = ~show_lap;
      if (halt) begin if ($urandom_range(0, 39) == 0) halt = 0; end
      else if ($urandom_range(0, 299) == 0) halt = 1;
      step();
      n_checks++; if (bcd !== sec_to_bcd(m_val)) begin n_fail++; $display("FAIL rnd_bcd @%0d: got %h expected %h", i, bcd, sec_to_bcd(m_val)); end
      n_checks++; if (lap_bcd !== sec_to_bcd(m_lap)) begin n_fail++; $display("FAIL rnd_lap @%0d: got %h expected %h", i, lap_bcd, sec_to_bcd(m_lap)); end
      n_checks++; if (running !== m_run) begin n_fail++; $display("FAIL rnd_running @%0d: got %b expected %b", i, running, m_run); end
      n_checks++; if (expired !== m_exp) begin n_fail++; $display("FAIL rnd_expired @%0d: got %b expected %b", i, expired, m_exp); end
      n_checks++; if (an !== m_an) begin n_fail++; $display("FAIL rnd_an @%0d: got %b expected %b", i, an, m_an); end
      n_checks++; if (seg !== m_seg) begin n_fail++; $display("FAIL rnd_seg @%0d: got %h expected %h", i, seg, m_seg); end
    end
    start_stop = 0; clear = 0; load = 0; lap = 0; halt = 0; show_lap = 0;
    $display("test_random done, %0d new failures", n_fail - fails_before);
  endtask

  task automatic test_async_reset();
    mode = 0; clear = 1; step(); clear = 0;
    start_stop = 1; step(); start_stop = 0;
    repeat (10) step();
    #3 rst_n = 0;
    model_reset();
    #2;
    n_checks++; if (bcd !== 16'h0000 || lap_bcd !== 16'h0000) begin n_fail++; $display("FAIL async_reset_values: got bcd=%h lap=%h expected 0000 0000", bcd, lap_bcd); end
    n_checks++; if (running !== 1'b0 || expired !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0) begin n_fail++; $display("FAIL async_reset_outputs: got run=%b exp=%b an=%b seg=%h expected 0 0 1110 c0", running, expired, an, seg); end
    @(posedge clk);
    #4 rst_n = 1;
    repeat (8) step();
    n_checks++; if (bcd !== 16'h0000 || running !== 1'b0) begin n_fail++; $display("FAIL async_reset_no_tick: got %h run=%b expected 0000 0", bcd, running); end
    $display("test_async_reset done");
  endtask

  initial begin
    model_reset();
    #22 rst_n = 1;
    test_reset();
    test_up_count();
    test_down_expiry();
    test_pause();
    test_priority();
    test_lap_display();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
